// File: rtl/alu_seq.sv
// Multi-cycle ALU with a valid/ready handshake and a persistent Z/S/C/V status register.
// Logic, add/sub and compare finish in one cycle; shifts/rotates move one bit per cycle; MUL is shift-add.
module alu_seq #(
    parameter int WIDTH = 20,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_c,
    output logic             flag_v,
    input  logic             flags_ld,
    input  logic [3:0]       flags_in
);

    localparam int HW = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH - HW){1'b0}}, {HW{1'b1}}};
    localparam logic [WIDTH-1:0] FULL_TOP  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] HALF_TOP  = {{(WIDTH - HW){1'b0}}, 1'b1, {(HW - 1){1'b0}}};
    localparam logic [CW-1:0]    E_FULL    = CW'(WIDTH);
    localparam logic [CW-1:0]    E_HALF    = CW'(HW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NOT = 4'h0, OP_AND = 4'h1, OP_OR  = 4'h2, OP_XOR = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SUB = 4'h6, OP_SBC = 4'h7,
        OP_SHR = 4'h8, OP_SHL = 4'h9, OP_ROR = 4'hA, OP_ROL = 4'hB,
        OP_MUL = 4'hC, OP_CMP = 4'hD, OP_INC = 4'hE, OP_DEC = 4'hF
    } op_t;

    function automatic logic topBit(input logic [WIDTH-1:0] x, input logic full);
        return full ? x[WIDTH-1] : x[HW-1];
    endfunction

    function automatic logic [WIDTH-1:0] widthMask(input logic full);
        return full ? {WIDTH{1'b1}} : HALF_MASK;
    endfunction

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               fz_q, fz_d;
    logic               fs_q, fs_d;
    logic               fc_q, fc_d;
    logic               fv_q, fv_d;

    logic [WIDTH-1:0]   maskQ;
    logic [WIDTH-1:0]   operB;
    logic [WIDTH:0]     addExt;
    logic [WIDTH:0]     subExt;
    logic [WIDTH-1:0]   addRes;
    logic [WIDTH-1:0]   subRes;
    logic               addC, addV, subC, subV;
    logic [WIDTH-1:0]   shStep;
    logic               shOut;
    logic [2*WIDTH-1:0] prodStep;
    logic               mulHigh;

    logic [WIDTH-1:0]   inMask;
    logic [CW-1:0]      nRaw, nShift, nRot, eIn;
    logic               isShift;

    logic               finish;
    logic               writeRes;
    logic [WIDTH-1:0]   doneRes;
    logic               doneC, doneV;

    // E-bit add/subtract shared by ADD/ADC/INC and SUB/SBC/DEC/CMP; carry/borrow taken at bit E
    always_comb begin
        maskQ  = widthMask(mode_q);
        operB  = (op_q == OP_INC || op_q == OP_DEC) ? {{(WIDTH - 1){1'b0}}, 1'b1} : b_q;
        addExt = {1'b0, a_q} + {1'b0, operB} + {{WIDTH{1'b0}}, (op_q == OP_ADC) & cin_q};
        subExt = {1'b0, a_q} - {1'b0, operB} - {{WIDTH{1'b0}}, (op_q == OP_SBC) & cin_q};
        addRes = addExt[WIDTH-1:0] & maskQ;
        subRes = subExt[WIDTH-1:0] & maskQ;
        addC   = mode_q ? addExt[WIDTH] : addExt[HW];
        subC   = mode_q ? subExt[WIDTH] : subExt[HW];
        addV   = (topBit(a_q, mode_q) == topBit(operB, mode_q)) &&
                 (topBit(addRes, mode_q) != topBit(a_q, mode_q));
        subV   = (topBit(a_q, mode_q) != topBit(operB, mode_q)) &&
                 (topBit(subRes, mode_q) != topBit(a_q, mode_q));
    end

    // One-bit shift/rotate step within the E-bit window; operand upper bits are already zero
    always_comb begin
        shStep = a_q;
        shOut  = 1'b0;
        case (op_q)
            OP_SHR: begin
                shStep = a_q >> 1;
                shOut  = a_q[0];
            end
            OP_SHL: begin
                shStep = (a_q << 1) & maskQ;
                shOut  = topBit(a_q, mode_q);
            end
            OP_ROR: shStep = (a_q >> 1) | (a_q[0] ? (mode_q ? FULL_TOP : HALF_TOP) : '0);
            OP_ROL: shStep = ((a_q << 1) & maskQ) | {{(WIDTH - 1){1'b0}}, topBit(a_q, mode_q)};
            default: ;
        endcase
        prodStep = prod_q + (b_q[0] ? mcand_q : '0);
        mulHigh  = mode_q ? (|prodStep[2*WIDTH-1:WIDTH]) : (|prodStep[2*WIDTH-1:HW]);
    end

    // Iteration count taken at accept time: clamped for shifts, modulo E for rotates
    always_comb begin
        inMask = widthMask(mode);
        eIn    = mode ? E_FULL : E_HALF;
        nRaw   = CW'(b[SHW-1:0]);
        nShift = (nRaw > eIn) ? eIn : nRaw;
        nRot   = mode ? (nRaw % E_FULL) : (nRaw % E_HALF);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        res_d    = res_q;
        fz_d     = fz_q;
        fs_d     = fs_q;
        fc_d     = fc_q;
        fv_d     = fv_q;
        finish   = 1'b0;
        writeRes = 1'b1;
        doneRes  = res_q;
        doneC    = 1'b0;
        doneV    = 1'b0;
        isShift  = (op_q == OP_SHR) || (op_q == OP_SHL) || (op_q == OP_ROR) || (op_q == OP_ROL);

        case (state_q)
            ST_IDLE: begin
                if (flags_ld) begin
                    {fz_d, fs_d, fc_d, fv_d} = flags_in;
                end
                if (in_valid) begin
                    op_d    = op_t'(op);
                    mode_d  = mode;
                    a_d     = a & inMask;
                    b_d     = b & inMask;
                    cin_d   = flags_ld ? flags_in[1] : fc_q;
                    prod_d  = '0;
                    mcand_d = {{WIDTH{1'b0}}, a & inMask};
                    case (op_t'(op))
                        OP_SHR, OP_SHL: cnt_d = nShift;
                        OP_ROR, OP_ROL: cnt_d = nRot;
                        OP_MUL:         cnt_d = eIn;
                        default:        cnt_d = '0;
                    endcase
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (isShift) begin
                    if (cnt_q == '0) begin
                        finish  = 1'b1;
                        doneRes = a_q;
                    end else begin
                        a_d   = shStep;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            finish  = 1'b1;
                            doneRes = shStep;
                            doneC   = (op_q == OP_SHR || op_q == OP_SHL) ? shOut : 1'b0;
                        end
                    end
                end else if (op_q == OP_MUL) begin
                    prod_d  = prodStep;
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q <= CW'(1)) begin
                        finish  = 1'b1;
                        doneRes = prodStep[WIDTH-1:0] & maskQ;
                        doneC   = mulHigh;
                        doneV   = mulHigh;
                    end
                end else begin
                    finish = 1'b1;
                    case (op_q)
                        OP_NOT: doneRes = ~a_q & maskQ;
                        OP_AND: doneRes = a_q & b_q;
                        OP_OR:  doneRes = a_q | b_q;
                        OP_XOR: doneRes = a_q ^ b_q;
                        OP_ADD, OP_ADC, OP_INC: begin
                            doneRes = addRes;
                            doneC   = addC;
                            doneV   = addV;
                        end
                        default: begin
                            doneRes  = subRes;
                            doneC    = subC;
                            doneV    = subV;
                            writeRes = (op_q != OP_CMP);
                        end
                    endcase
                end
                if (finish) begin
                    state_d = ST_DONE;
                    if (writeRes) begin
                        res_d = doneRes;
                    end
                    fz_d = ((doneRes & maskQ) == '0);
                    fs_d = topBit(doneRes, mode_q);
                    fc_d = doneC;
                    fv_d = doneV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOT;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            fz_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            fz_q    <= fz_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
            fv_q    <= fv_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign c         = res_q;
    assign flag_z    = fz_q;
    assign flag_s    = fs_q;
    assign flag_c    = fc_q;
    assign flag_v    = fv_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=20) with hand sequences for
// back-pressure, flag loading and reset during an iterative op.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        mode;
    logic [19:0] a;
    logic [19:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] c;
    logic        flag_z, flag_s, flag_c, flag_v;
    logic        flags_ld;
    logic [3:0]  flags_in;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        logic [3:0]  op;
        logic        mode;
        logic [19:0] a;
        logic [19:0] b;
        logic [19:0] expC;
        logic [3:0]  expF;
        int          expLat;
    } vec_t;

    vec_t vecs[20];

    alu_seq #(.WIDTH(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flag_z    (flag_z),
        .flag_s    (flag_s),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flags_ld  (flags_ld),
        .flags_in  (flags_in)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] flagsNow();
        return {28'd0, flag_z, flag_s, flag_c, flag_v};
    endfunction

    // Presents one request on a falling edge; returns #1 after the accepting rising edge
    task automatic startOp(input logic [3:0] o, input logic m, input logic [19:0] x, input logic [19:0] y,
                           input logic ld, input logic [3:0] fin);
        @(negedge clk);
        op       = o;
        mode     = m;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        flags_ld = ld;
        flags_in = fin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flags_ld = 1'b0;
    endtask

    // Counts rising edges after acceptance until out_valid; -1 on timeout
    task automatic waitResult(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic m, input logic [19:0] x, input logic [19:0] y,
                                 input logic ld, input logic [3:0] fin, output int lat);
        startOp(o, m, x, y, ld, fin);
        waitResult(lat);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{4'h4, 1'b1, 20'hFFFFF, 20'h00001, 20'h00000, 4'b1010, 1};
        vecs[1]  = '{4'h4, 1'b0, 20'h123FF, 20'h00001, 20'h00000, 4'b1010, 1};
        vecs[2]  = '{4'h4, 1'b0, 20'h001FF, 20'h00001, 20'h00200, 4'b0101, 1};
        vecs[3]  = '{4'h6, 1'b1, 20'h00005, 20'h00007, 20'hFFFFE, 4'b0110, 1};
        vecs[4]  = '{4'h1, 1'b1, 20'hF0F0F, 20'h0FF00, 20'h00F00, 4'b0000, 1};
        vecs[5]  = '{4'h2, 1'b1, 20'hA0000, 20'h00005, 20'hA0005, 4'b0100, 1};
        vecs[6]  = '{4'h3, 1'b1, 20'h12345, 20'h12345, 20'h00000, 4'b1000, 1};
        vecs[7]  = '{4'h0, 1'b0, 20'h12300, 20'h00000, 20'h000FF, 4'b0000, 1};
        vecs[8]  = '{4'hE, 1'b1, 20'h7FFFF, 20'h00000, 20'h80000, 4'b0101, 1};
        vecs[9]  = '{4'hF, 1'b0, 20'h00000, 20'h00000, 20'h003FF, 4'b0110, 1};
        vecs[10] = '{4'hD, 1'b1, 20'h00003, 20'h00003, 20'h003FF, 4'b1000, 1};
        vecs[11] = '{4'h9, 1'b1, 20'h20001, 20'h00003, 20'h00008, 4'b0010, 3};
        vecs[12] = '{4'h8, 1'b1, 20'h12345, 20'h00000, 20'h12345, 4'b0000, 1};
        vecs[13] = '{4'h8, 1'b0, 20'h00305, 20'h00002, 20'h000C1, 4'b0000, 2};
        vecs[14] = '{4'hA, 1'b0, 20'h00001, 20'h0000B, 20'h00200, 4'b0100, 1};
        vecs[15] = '{4'hB, 1'b1, 20'h80000, 20'h00001, 20'h00001, 4'b0000, 1};
        vecs[16] = '{4'h9, 1'b0, 20'h003FF, 20'h0001F, 20'h00000, 4'b1010, 10};
        vecs[17] = '{4'hC, 1'b1, 20'h00400, 20'h00400, 20'h00000, 4'b1011, 20};
        vecs[18] = '{4'h5, 1'b1, 20'h00001, 20'h00001, 20'h00003, 4'b0000, 1};
        vecs[19] = '{4'hC, 1'b0, 20'h0000F, 20'h0000F, 20'h000E1, 4'b0000, 10};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        mode      = 1'b1;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        flags_ld  = 1'b0;
        flags_in  = 4'b0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset c", 32'(c), 32'd0);
        checkOutput("reset flags", flagsNow(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0, 4'b0000, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d c", i), 32'(c), 32'(vecs[i].expC));
            checkOutput($sformatf("vec%0d flags", i), flagsNow(), 32'(vecs[i].expF));
            @(posedge clk);
            #1;
        end

        // Back-pressure: result held, new requests and flags_ld ignored outside IDLE
        out_ready = 1'b0;
        applyStimulus(4'h4, 1'b1, 20'h00002, 20'h00003, 1'b0, 4'b0000, lat);
        checkOutput("bp latency", 32'(lat), 32'd1);
        checkOutput("bp c", 32'(c), 32'h5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            op       = 4'h4;
            a        = 20'h00007;
            b        = 20'h00007;
            in_valid = 1'b1;
            flags_ld = 1'b1;
            flags_in = 4'b1111;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold%0d c", k), 32'(c), 32'h5);
            checkOutput($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp hold%0d flags", k), flagsNow(), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        flags_ld  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp no second op", 32'(out_valid), 32'd0);
        checkOutput("bp c kept", 32'(c), 32'h5);

        // flags_ld in IDLE, then SBC consumes the loaded carry
        @(negedge clk);
        flags_ld = 1'b1;
        flags_in = 4'b0010;
        @(posedge clk);
        #1;
        flags_ld = 1'b0;
        checkOutput("flags_ld value", flagsNow(), 32'b0010);
        applyStimulus(4'h7, 1'b1, 20'h00005, 20'h00002, 1'b0, 4'b0000, lat);
        checkOutput("sbc latency", 32'(lat), 32'd1);
        checkOutput("sbc c", 32'(c), 32'h2);
        checkOutput("sbc flags", flagsNow(), 32'b0000);
        @(posedge clk);
        #1;

        // flags_ld together with an accepted ADC: carry-in comes from flags_in
        applyStimulus(4'h5, 1'b1, 20'h00001, 20'h00001, 1'b1, 4'b0010, lat);
        checkOutput("ld+adc latency", 32'(lat), 32'd1);
        checkOutput("ld+adc c", 32'(c), 32'h3);
        checkOutput("ld+adc flags", flagsNow(), 32'b0000);
        @(posedge clk);
        #1;

        // Reset mid-MUL after a result that left c and flags non-zero
        applyStimulus(4'h6, 1'b1, 20'h00001, 20'h00002, 1'b0, 4'b0000, lat);
        checkOutput("pre-reset c", 32'(c), 32'hFFFFF);
        @(posedge clk);
        #1;
        startOp(4'hC, 1'b1, 20'h00400, 20'h00400, 1'b0, 4'b0000);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("mid-mul busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort c", 32'(c), 32'd0);
        checkOutput("abort flags", flagsNow(), 32'd0);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'h4, 1'b1, 20'h00001, 20'h00001, 1'b0, 4'b0000, lat);
        checkOutput("post-reset latency", 32'(lat), 32'd1);
        checkOutput("post-reset c", 32'(c), 32'h2);
        checkOutput("post-reset flags", flagsNow(), 32'b0000);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
